// File: rtl/aurora_frame_pkg.sv
// Shared Aurora framing definitions: FSM state encoding and header word layout.
// Imported by the TX framer and by the RX deframer.
package aurora_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CSUM    = 2'd3
  } frame_state_e;

  localparam logic [15:0] AURORA_HDR_MAGIC = 16'hA5C3;

  localparam int HDR_MAGIC_MSB = 31;
  localparam int HDR_MAGIC_LSB = 16;
  localparam int HDR_SEQ_MSB   = 15;
  localparam int HDR_SEQ_LSB   = 8;
  localparam int HDR_LEN_MSB   = 7;
  localparam int HDR_LEN_LSB   = 0;

  function automatic logic [31:0] build_header(input logic [7:0] seq, input logic [7:0] len_m1);
    logic [31:0] hdr;
    hdr = 32'h0;
    hdr[HDR_MAGIC_MSB:HDR_MAGIC_LSB] = AURORA_HDR_MAGIC;
    hdr[HDR_SEQ_MSB:HDR_SEQ_LSB]     = seq;
    hdr[HDR_LEN_MSB:HDR_LEN_LSB]     = len_m1;
    return hdr;
  endfunction

endpackage

// File: rtl/aurora_tx_framer.sv
// Packetizes a 32-bit word stream into fixed-length Aurora frames on the AXI4-Stream TX port.
// Define AURORA_TX_CHKSUM_EN to append a 32-bit wrapping-sum trailer word to every frame.
module aurora_tx_framer
  import aurora_frame_pkg::*;
#(
  parameter int FRAME_LEN = 64,
  parameter int TIMEOUT   = 1024
) (
  input  logic        user_clk,
  input  logic        rst_n,
  input  logic        channel_up,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] s_axi_tx_tdata,
  output logic [3:0]  s_axi_tx_tkeep,
  output logic        s_axi_tx_tlast,
  output logic        s_axi_tx_tvalid,
  input  logic        s_axi_tx_tready,
  output logic        frame_done,
  output logic        frame_drop,
  output logic [15:0] pad_words,
  output logic [7:0]  seq_num
);

  localparam logic [8:0]  LAST_WORD = 9'(FRAME_LEN - 1);
  localparam logic [7:0]  LEN_FIELD = 8'(FRAME_LEN - 1);
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  frame_state_e state_r;
  frame_state_e state_s;
  logic [31:0]  data_r;
  logic [8:0]   wcnt_r;
  logic [15:0]  to_cnt_r;
  logic         pad_mode_r;
  logic [7:0]   seq_r;
  logic [15:0]  pad_cnt_r;
  logic         frame_done_r;
  logic         frame_drop_r;

  logic         tvalid_s;
  logic [31:0]  tdata_s;
  logic         tlast_s;
  logic         in_ready_s;
  logic         xfer_s;
  logic         drop_s;
  logic         done_s;
  logic         last_word_s;

  assign last_word_s = (wcnt_r == LAST_WORD);

  // TX/input handshake outputs and next-state selection
  always_comb begin
    tvalid_s   = 1'b0;
    tdata_s    = 32'h0;
    tlast_s    = 1'b0;
    in_ready_s = 1'b0;
    state_s    = state_r;
    case (state_r)
      ST_HDR: begin
        tvalid_s = 1'b1;
        tdata_s  = data_r;
      end
      ST_PAYLOAD: begin
        tvalid_s   = in_valid | pad_mode_r;
        tdata_s    = pad_mode_r ? 32'h0 : in_data;
        in_ready_s = s_axi_tx_tready & ~pad_mode_r;
`ifdef AURORA_TX_CHKSUM_EN
        tlast_s    = 1'b0;
`else
        tlast_s    = last_word_s;
`endif
      end
`ifdef AURORA_TX_CHKSUM_EN
      ST_CSUM: begin
        tvalid_s = 1'b1;
        tdata_s  = data_r;
        tlast_s  = 1'b1;
      end
`endif
      default: begin
        tvalid_s = 1'b0;
      end
    endcase

    xfer_s = tvalid_s & s_axi_tx_tready;
    // A lost channel overrides whatever handshake happens in the same cycle
    drop_s = (state_r != ST_IDLE) & ~channel_up;
    done_s = xfer_s & tlast_s & ~drop_s;

    if (drop_s) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (channel_up && in_valid) state_s = ST_HDR;
          else state_s = ST_IDLE;
        end
        ST_HDR: begin
          if (xfer_s) state_s = ST_PAYLOAD;
          else state_s = ST_HDR;
        end
        ST_PAYLOAD: begin
          if (xfer_s && last_word_s) begin
`ifdef AURORA_TX_CHKSUM_EN
            state_s = ST_CSUM;
`else
            state_s = ST_IDLE;
`endif
          end else begin
            state_s = ST_PAYLOAD;
          end
        end
`ifdef AURORA_TX_CHKSUM_EN
        ST_CSUM: begin
          if (xfer_s) state_s = ST_IDLE;
          else state_s = ST_CSUM;
        end
`endif
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State, counters, header/checksum word and status pulses
  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      data_r       <= 32'h0;
      wcnt_r       <= 9'd0;
      to_cnt_r     <= 16'd0;
      pad_mode_r   <= 1'b0;
      seq_r        <= 8'd0;
      pad_cnt_r    <= 16'd0;
      frame_done_r <= 1'b0;
      frame_drop_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      frame_done_r <= done_s;
      frame_drop_r <= drop_s;
      if (drop_s) begin
        wcnt_r     <= 9'd0;
        to_cnt_r   <= 16'd0;
        pad_mode_r <= 1'b0;
        // Past the header the sequence number was already advanced; take it back
        if (state_r != ST_HDR) seq_r <= seq_r - 8'd1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            data_r     <= build_header(seq_r, LEN_FIELD);
            wcnt_r     <= 9'd0;
            to_cnt_r   <= 16'd0;
            pad_mode_r <= 1'b0;
          end
          ST_HDR: begin
            if (xfer_s) seq_r <= seq_r + 8'd1;
          end
          ST_PAYLOAD: begin
            if (xfer_s) begin
              wcnt_r <= wcnt_r + 9'd1;
`ifdef AURORA_TX_CHKSUM_EN
              data_r <= data_r + tdata_s;
`endif
              if (pad_mode_r) pad_cnt_r <= pad_cnt_r + 16'd1;
            end
            if (in_valid && in_ready_s) begin
              to_cnt_r <= 16'd0;
            end else if (!in_valid && !pad_mode_r) begin
              to_cnt_r <= to_cnt_r + 16'd1;
              if (to_cnt_r + 16'd1 == TIMEOUT_W) pad_mode_r <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign s_axi_tx_tvalid = tvalid_s;
  assign s_axi_tx_tdata  = tdata_s;
  assign s_axi_tx_tlast  = tlast_s;
  assign s_axi_tx_tkeep  = 4'hF;
  assign in_ready        = in_ready_s;
  assign frame_done      = frame_done_r;
  assign frame_drop      = frame_drop_r;
  assign pad_words       = pad_cnt_r;
  assign seq_num         = seq_r;

endmodule

// File: tb/tb_aurora_tx_framer.sv
// Directed bench for aurora_tx_framer with FRAME_LEN=4, TIMEOUT=8.
// Works for both builds; AURORA_TX_CHKSUM_EN selects the trailer expectations.
module tb_aurora_tx_framer;

  localparam int FL = 4;
  localparam int TO = 8;
`ifdef AURORA_TX_CHKSUM_EN
  localparam int          TOTAL       = FL + 2;
  localparam logic [31:0] FIRST_LAST  = 32'hA5C3000D;
  localparam logic        PAD_HAS_LAST = 1'b0;
`else
  localparam int          TOTAL       = FL + 1;
  localparam logic [31:0] FIRST_LAST  = 32'd4;
  localparam logic        PAD_HAS_LAST = 1'b1;
`endif

  logic        user_clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        channel_up = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] s_axi_tx_tdata;
  logic [3:0]  s_axi_tx_tkeep;
  logic        s_axi_tx_tlast;
  logic        s_axi_tx_tvalid;
  logic        s_axi_tx_tready = 1'b0;
  logic        frame_done;
  logic        frame_drop;
  logic [15:0] pad_words;
  logic [7:0]  seq_num;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  exp_seq = 8'd0;
  logic [31:0] next_word = 32'd1;
  logic [31:0] last_obs = 32'h0;
  logic [31:0] sum = 32'h0;

  aurora_tx_framer #(.FRAME_LEN(FL), .TIMEOUT(TO)) dut (
    .user_clk        (user_clk),
    .rst_n           (rst_n),
    .channel_up      (channel_up),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .s_axi_tx_tdata  (s_axi_tx_tdata),
    .s_axi_tx_tkeep  (s_axi_tx_tkeep),
    .s_axi_tx_tlast  (s_axi_tx_tlast),
    .s_axi_tx_tvalid (s_axi_tx_tvalid),
    .s_axi_tx_tready (s_axi_tx_tready),
    .frame_done      (frame_done),
    .frame_drop      (frame_drop),
    .pad_words       (pad_words),
    .seq_num         (seq_num)
  );

  always #5 user_clk = ~user_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_tx(input string tag, input logic [31:0] d, input logic l, input logic r);
    chk({tag, ".tvalid"}, 32'(s_axi_tx_tvalid), 32'd1);
    chk({tag, ".tdata"}, s_axi_tx_tdata, d);
    chk({tag, ".tlast"}, 32'(s_axi_tx_tlast), 32'(l));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(r));
    chk({tag, ".tkeep"}, 32'(s_axi_tx_tkeep), 32'hF);
  endtask

  task automatic next_cyc();
    @(posedge user_clk);
    #1;
  endtask

  // Runs one frame from its IDLE cycle; drop_idx >= 0 pulls channel_up low on that frame word.
  task automatic run_frame(input bit rnd, input logic exp_done, input int drop_idx);
    int          idx;
    int          cyc;
    bit          dropped;
    logic [31:0] exp_d;
    logic [31:0] acc;
    logic [7:0]  seq0;
    in_valid = 1'b1;
    in_data  = next_word;
    @(negedge user_clk);
    chk("idle.tvalid", 32'(s_axi_tx_tvalid), 32'd0);
    chk("idle.in_ready", 32'(in_ready), 32'd0);
    chk("idle.frame_done", 32'(frame_done), 32'(exp_done));
    chk("idle.frame_drop", 32'(frame_drop), 32'd0);
    chk("idle.seq_num", 32'(seq_num), 32'(exp_seq));
    seq0 = exp_seq;
    next_cyc();
    idx = 0; cyc = 0; dropped = 1'b0; acc = 32'h0;
    while (idx < TOTAL && !dropped && cyc < 100) begin
      s_axi_tx_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx == drop_idx) channel_up = 1'b0;
      in_data = next_word;
      if (idx == 0) exp_d = {16'hA5C3, exp_seq, 8'(FL - 1)};
      else if (idx <= FL) exp_d = next_word;
      else exp_d = acc;
      @(negedge user_clk);
      chk_tx("frame", exp_d, idx == TOTAL - 1, (idx >= 1 && idx <= FL) ? s_axi_tx_tready : 1'b0);
      last_obs = s_axi_tx_tdata;
      if (idx == drop_idx) begin
        dropped = 1'b1;
      end else if (s_axi_tx_tready) begin
        acc = acc + exp_d;
        if (idx >= 1 && idx <= FL) next_word++;
        if (idx == 0) exp_seq++;
        idx++;
      end
      cyc++;
      next_cyc();
    end
    chk("frame.budget", 32'(cyc < 100), 32'd1);
    if (dropped) begin
      if (idx >= 1 && idx <= FL) next_word++;
      exp_seq = seq0;
      @(negedge user_clk);
      chk("drop.tvalid", 32'(s_axi_tx_tvalid), 32'd0);
      chk("drop.frame_drop", 32'(frame_drop), 32'd1);
      chk("drop.frame_done", 32'(frame_done), 32'd0);
      chk("drop.seq_num", 32'(seq_num), 32'(seq0));
      next_cyc();
      channel_up = 1'b1;
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    @(negedge user_clk);
    chk("rst.tvalid", 32'(s_axi_tx_tvalid), 32'd0);
    chk("rst.tlast", 32'(s_axi_tx_tlast), 32'd0);
    chk("rst.tdata", s_axi_tx_tdata, 32'h0);
    chk("rst.tkeep", 32'(s_axi_tx_tkeep), 32'hF);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.frame_done", 32'(frame_done), 32'd0);
    chk("rst.frame_drop", 32'(frame_drop), 32'd0);
    chk("rst.pad_words", 32'(pad_words), 32'd0);
    chk("rst.seq_num", 32'(seq_num), 32'd0);
    next_cyc();
    rst_n = 1'b1;
    channel_up = 1'b1;

    // Basic frame: words 1..4 with tready held high
    run_frame(1'b0, 1'b0, -1);
    chk("first.last_word", last_obs, FIRST_LAST);
    chk("first.seq_num", 32'(seq_num), 32'd1);

    // 255 more frames with random backpressure; sequence number wraps to 0
    for (int f = 1; f < 256; f++) run_frame(1'b1, 1'b1, -1);
    chk("wrap.seq_num", 32'(seq_num), 32'd0);

    // Timeout padding: one real word, then input stalls
    s_axi_tx_tready = 1'b1;
    in_valid = 1'b1;
    in_data = next_word;
    @(negedge user_clk);
    chk("to.idle_done", 32'(frame_done), 32'd1);
    next_cyc();
    @(negedge user_clk);
    chk_tx("to.hdr", {16'hA5C3, exp_seq, 8'(FL - 1)}, 1'b0, 1'b0);
    sum = {16'hA5C3, exp_seq, 8'(FL - 1)};
    exp_seq++;
    next_cyc();
    @(negedge user_clk);
    chk_tx("to.w1", next_word, 1'b0, 1'b1);
    sum = sum + next_word;
    next_word++;
    next_cyc();
    in_valid = 1'b0;
    for (int i = 0; i < TO; i++) begin
      @(negedge user_clk);
      chk("to.wait.tvalid", 32'(s_axi_tx_tvalid), 32'd0);
      next_cyc();
    end
    for (int i = 0; i < FL - 1; i++) begin
      in_valid = (i == FL - 2);
      in_data  = 32'hDEADBEEF;
      @(negedge user_clk);
      chk_tx("to.pad", 32'h0, PAD_HAS_LAST && (i == FL - 2), 1'b0);
      next_cyc();
    end
    in_valid = 1'b0;
`ifdef AURORA_TX_CHKSUM_EN
    @(negedge user_clk);
    chk_tx("to.csum", sum, 1'b1, 1'b0);
    next_cyc();
`endif
    @(negedge user_clk);
    chk("to.frame_done", 32'(frame_done), 32'd1);
    chk("to.pad_words", 32'(pad_words), 32'd3);
    chk("to.tvalid", 32'(s_axi_tx_tvalid), 32'd0);
    next_cyc();

    // Channel loss during payload word 2, then on the final word
    run_frame(1'b0, 1'b0, 2);
    run_frame(1'b0, 1'b0, TOTAL - 1);
    run_frame(1'b0, 1'b0, -1);

    // Asynchronous reset in the middle of a payload
    in_valid = 1'b1;
    in_data = next_word;
    @(negedge user_clk);
    chk("rst2.idle_done", 32'(frame_done), 32'd1);
    next_cyc();
    @(negedge user_clk);
    chk_tx("rst2.hdr", {16'hA5C3, exp_seq, 8'(FL - 1)}, 1'b0, 1'b0);
    next_cyc();
    next_word++;
    in_data = next_word;
    #2 rst_n = 1'b0;
    #1;
    chk("rst2.tvalid", 32'(s_axi_tx_tvalid), 32'd0);
    chk("rst2.tdata", s_axi_tx_tdata, 32'h0);
    chk("rst2.tlast", 32'(s_axi_tx_tlast), 32'd0);
    chk("rst2.tkeep", 32'(s_axi_tx_tkeep), 32'hF);
    chk("rst2.in_ready", 32'(in_ready), 32'd0);
    chk("rst2.frame_done", 32'(frame_done), 32'd0);
    chk("rst2.frame_drop", 32'(frame_drop), 32'd0);
    chk("rst2.pad_words", 32'(pad_words), 32'd0);
    chk("rst2.seq_num", 32'(seq_num), 32'd0);
    exp_seq = 8'd0;
    next_cyc();
    rst_n = 1'b1;
    run_frame(1'b0, 1'b0, -1);
    @(negedge user_clk);
    chk("end.frame_done", 32'(frame_done), 32'd1);
    chk("end.seq_num", 32'(seq_num), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
